// File: rtl/vending_if.sv
// Panel-side bundle of the vending controller: operator inputs plus dispense/change actuator outputs.
interface vending_if #(
  parameter int KIND_W   = 2,
  parameter int PRICE_W  = 8,
  parameter int NUM_W    = 3,
  parameter int CREDIT_W = 10
);
  logic                start;
  logic                admin;
  logic                price_wr;
  logic [PRICE_W-1:0]  price_val;
  logic [KIND_W-1:0]   kind;
  logic [NUM_W-1:0]    num;
  logic                coin_valid;
  logic [1:0]          coin;
  logic                enter;
  logic                cancel;
  logic [2:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic [PRICE_W-1:0]  price;
  logic                made;
  logic [KIND_W-1:0]   made_kind;
  logic                coin_reject;
  logic                change_valid;
  logic [1:0]          change_coin;
  logic                err;
  logic                session_end;

  modport master (
    output start, admin, price_wr, price_val, kind, num, coin_valid, coin, enter, cancel,
    input  state, credit, price, made, made_kind, coin_reject, change_valid, change_coin,
           err, session_end
  );

  modport slave (
    input  start, admin, price_wr, price_val, kind, num, coin_valid, coin, enter, cancel,
    output state, credit, price, made, made_kind, coin_reject, change_valid, change_coin,
           err, session_end
  );
endinterface

// File: rtl/vending_core_multi.sv
// Multi-product vending controller: admin pricing, coin intake, multi-unit purchase, greedy change.
// Optional AUTO_REFUND_TIMEOUT_EN: refund credit after TIMEOUT_CYC idle cycles in COLLECT.
module vending_core_multi #(
  parameter int NUM_KINDS     = 4,
  parameter int PRICE_W       = 8,
  parameter int NUM_W         = 3,
  parameter int CREDIT_W      = 10,
  parameter int DEFAULT_PRICE = 20,
  parameter int MAX_CREDIT    = 400
`ifdef AUTO_REFUND_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic      clk,
  input  logic      rst_n,
  vending_if.slave  bus
);
  localparam int KIND_W = $clog2(NUM_KINDS);
  localparam int COST_W = PRICE_W + NUM_W;
  localparam int CMP_W  = (COST_W > CREDIT_W) ? COST_W : CREDIT_W;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADMIN    = 3'd1;
  localparam logic [2:0] ST_COLLECT  = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_DISPENSE = 3'd4;
  localparam logic [2:0] ST_CHANGE   = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  logic [2:0]          state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [KIND_W-1:0]   kind_reg, kind_next;
  logic [NUM_W-1:0]    num_reg, num_next;
  logic [NUM_W-1:0]    cnt_reg, cnt_next;
  logic [PRICE_W-1:0]  price_reg [NUM_KINDS];
  logic [NUM_KINDS-1:0] wr_hit;

  logic [PRICE_W-1:0]  price_rd, chk_price;
  logic                kind_ok;
  logic [COST_W-1:0]   cost;
  logic                cost_ok;
  logic [CREDIT_W-1:0] coin_val, chg_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [1:0]          chg_code;
  logic                err_pulse, reject_pulse, timeout_hit;

  // A zero price would make a product free, so such writes are refused.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_KINDS; gi++) begin : g_wr
      assign wr_hit[gi] = (state_reg == ST_ADMIN) && bus.price_wr && (bus.price_val != '0)
                          && (bus.kind == KIND_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_KINDS; k++) begin
      if (!rst_n)
        price_reg[k] <= PRICE_W'(DEFAULT_PRICE);
      else if (wr_hit[k])
        price_reg[k] <= bus.price_val;
    end
  end

  always_comb begin
    price_rd  = '0;
    chk_price = '0;
    kind_ok   = 1'b0;
    for (int k = 0; k < NUM_KINDS; k++) begin
      if (bus.kind == KIND_W'(k))
        price_rd = price_reg[k];
      if (kind_reg == KIND_W'(k)) begin
        chk_price = price_reg[k];
        kind_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    case (bus.coin)
      2'd0:    coin_val = CREDIT_W'(1);
      2'd1:    coin_val = CREDIT_W'(2);
      2'd2:    coin_val = CREDIT_W'(10);
      default: coin_val = CREDIT_W'(20);
    endcase
  end

  assign coin_sum  = {1'b0, credit_reg} + {1'b0, coin_val};
  assign coin_fits = coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign cost      = COST_W'(chk_price) * COST_W'(num_reg);
  assign cost_ok   = (num_reg != '0) && kind_ok && (CMP_W'(cost) <= CMP_W'(credit_reg));

  // Largest coin that still fits in the remaining credit.
  always_comb begin
    if (credit_reg >= CREDIT_W'(20)) begin
      chg_code = 2'd3; chg_val = CREDIT_W'(20);
    end else if (credit_reg >= CREDIT_W'(10)) begin
      chg_code = 2'd2; chg_val = CREDIT_W'(10);
    end else if (credit_reg >= CREDIT_W'(2)) begin
      chg_code = 2'd1; chg_val = CREDIT_W'(2);
    end else begin
      chg_code = 2'd0; chg_val = CREDIT_W'(1);
    end
  end

`ifdef AUTO_REFUND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt_reg;
  logic            collect_activity;

  assign collect_activity = bus.coin_valid || bus.enter || bus.cancel;
  assign timeout_hit = (state_reg == ST_COLLECT) && !collect_activity
                       && (idle_cnt_reg == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != ST_COLLECT || collect_activity)
      idle_cnt_reg <= '0;
    else
      idle_cnt_reg <= idle_cnt_reg + TO_W'(1);
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    credit_next  = credit_reg;
    kind_next    = kind_reg;
    num_next     = num_reg;
    cnt_next     = cnt_reg;
    err_pulse    = 1'b0;
    reject_pulse = bus.coin_valid && !((state_reg == ST_COLLECT) && coin_fits);
    case (state_reg)
      ST_IDLE: begin
        if (bus.admin)
          state_next = ST_ADMIN;
        else if (bus.start)
          state_next = ST_COLLECT;
      end
      ST_ADMIN: begin
        if (bus.price_wr && bus.price_val == '0)
          err_pulse = 1'b1;
        if (!bus.admin)
          state_next = ST_IDLE;
      end
      ST_COLLECT: begin
        // A coin arriving with ENTER is credited before CHECK sees the credit.
        if (bus.coin_valid && coin_fits)
          credit_next = coin_sum[CREDIT_W-1:0];
        if (bus.cancel || timeout_hit) begin
          state_next = ST_CHANGE;
        end else if (bus.enter) begin
          state_next = ST_CHECK;
          kind_next  = bus.kind;
          num_next   = bus.num;
        end
      end
      ST_CHECK: begin
        if (cost_ok) begin
          credit_next = credit_reg - CREDIT_W'(cost);
          cnt_next    = num_reg;
          state_next  = ST_DISPENSE;
        end else begin
          err_pulse  = 1'b1;
          state_next = ST_COLLECT;
        end
      end
      ST_DISPENSE: begin
        cnt_next = cnt_reg - NUM_W'(1);
        if (cnt_reg == NUM_W'(1))
          state_next = ST_CHANGE;
      end
      ST_CHANGE: begin
        if (credit_reg == '0)
          state_next = ST_DONE;
        else
          credit_next = credit_reg - chg_val;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      credit_reg <= '0;
      kind_reg   <= '0;
      num_reg    <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      kind_reg   <= kind_next;
      num_reg    <= num_next;
      cnt_reg    <= cnt_next;
    end
  end

  assign bus.state        = state_reg;
  assign bus.credit       = credit_reg;
  assign bus.price        = price_rd;
  assign bus.made         = (state_reg == ST_DISPENSE);
  assign bus.made_kind    = kind_reg;
  assign bus.coin_reject  = reject_pulse;
  assign bus.change_valid = (state_reg == ST_CHANGE) && (credit_reg != '0);
  assign bus.change_coin  = chg_code;
  assign bus.err          = err_pulse;
  assign bus.session_end  = (state_reg == ST_DONE);
endmodule

// File: tb/tb_vending_core_multi.sv
// Directed, table-driven bench for vending_core_multi; one printed line per applied cycle.
module tb_vending_core_multi;
  localparam int KIND_W   = 2;
  localparam int PRICE_W  = 8;
  localparam int NUM_W    = 3;
  localparam int CREDIT_W = 10;
`ifdef AUTO_REFUND_TIMEOUT_EN
  localparam int TO_CYC = 20;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vending_if #(.KIND_W(KIND_W), .PRICE_W(PRICE_W), .NUM_W(NUM_W), .CREDIT_W(CREDIT_W)) bus ();

  vending_core_multi #(
    .NUM_KINDS(4), .PRICE_W(PRICE_W), .NUM_W(NUM_W), .CREDIT_W(CREDIT_W),
    .DEFAULT_PRICE(20), .MAX_CREDIT(400)
`ifdef AUTO_REFUND_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef enum int {NOP, START, WR, COIN, ENTER, ENTER_COIN, CANCEL, CANCEL_ENTER} op_e;

  // fl = {made, coin_reject, change_valid, err, session_end}
  typedef struct {
    op_e        op;
    logic       adm;
    logic [1:0] kind;
    logic [2:0] num;
    logic [1:0] coin;
    logic [7:0] pval;
    logic [2:0] st;
    int         cr;
    int         pr;
    logic [4:0] fl;
    logic [1:0] code;
    logic [1:0] mk;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;
  int   vidx  = 0;

  function automatic vec_t mk(op_e op, logic adm, logic [1:0] kind, logic [2:0] num,
                              logic [1:0] coin, logic [7:0] pval, logic [2:0] st, int cr,
                              int pr, logic [4:0] fl, logic [1:0] code, logic [1:0] mkind);
    vec_t v;
    v.op = op; v.adm = adm; v.kind = kind; v.num = num; v.coin = coin; v.pval = pval;
    v.st = st; v.cr = cr; v.pr = pr; v.fl = fl; v.code = code; v.mk = mkind;
    return v;
  endfunction

  function automatic void add(op_e op, logic adm, logic [1:0] kind, logic [2:0] num,
                              logic [1:0] coin, logic [7:0] pval, logic [2:0] st, int cr,
                              int pr, logic [4:0] fl, logic [1:0] code, logic [1:0] mkind);
    vq.push_back(mk(op, adm, kind, num, coin, pval, st, cr, pr, fl, code, mkind));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.start      = (v.op == START);
    bus.admin      = v.adm;
    bus.price_wr   = (v.op == WR);
    bus.price_val  = v.pval;
    bus.kind       = v.kind;
    bus.num        = v.num;
    bus.coin_valid = (v.op == COIN) || (v.op == ENTER_COIN);
    bus.coin       = v.coin;
    bus.enter      = (v.op == ENTER) || (v.op == ENTER_COIN) || (v.op == CANCEL_ENTER);
    bus.cancel     = (v.op == CANCEL) || (v.op == CANCEL_ENTER);
  endtask

  // Drive one cycle of inputs, compare at the falling edge, then advance past the rising edge.
  task automatic run(vec_t v);
    drive(v);
    @(negedge clk);
    chk($sformatf("v%0d.state", vidx), bus.state, v.st);
    chk($sformatf("v%0d.credit", vidx), bus.credit, v.cr);
    chk($sformatf("v%0d.price", vidx), bus.price, v.pr);
    chk($sformatf("v%0d.made", vidx), bus.made, v.fl[4]);
    chk($sformatf("v%0d.coin_reject", vidx), bus.coin_reject, v.fl[3]);
    chk($sformatf("v%0d.change_valid", vidx), bus.change_valid, v.fl[2]);
    chk($sformatf("v%0d.err", vidx), bus.err, v.fl[1]);
    chk($sformatf("v%0d.end", vidx), bus.session_end, v.fl[0]);
    if (v.fl[2]) chk($sformatf("v%0d.change_coin", vidx), bus.change_coin, v.code);
    if (v.fl[4]) chk($sformatf("v%0d.made_kind", vidx), bus.made_kind, v.mk);
    $display("vec %0d op=%0d state=%0d credit=%0d made=%0b chg=%0b/%0d err=%0b end=%0b",
             vidx, v.op, bus.state, bus.credit, bus.made, bus.change_valid, bus.change_coin,
             bus.err, bus.session_end);
    vidx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    // Three 1000-won coins buy three units of kind0 exactly; no change.
    add(START, 0, 0, 0, 0, 0,  0,  0, 20, 5'b00000, 0, 0);
    add(COIN,  0, 0, 0, 3, 0,  2,  0, 20, 5'b00000, 0, 0);
    add(COIN,  0, 0, 0, 3, 0,  2, 20, 20, 5'b00000, 0, 0);
    add(COIN,  0, 0, 0, 3, 0,  2, 40, 20, 5'b00000, 0, 0);
    add(ENTER, 0, 0, 3, 0, 0,  2, 60, 20, 5'b00000, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  3, 60, 20, 5'b00000, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  4,  0, 20, 5'b10000, 0, 0);
    add(COIN,  0, 0, 0, 3, 0,  4,  0, 20, 5'b11000, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  4,  0, 20, 5'b10000, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  5,  0, 20, 5'b00000, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  6,  0, 20, 5'b00001, 0, 0);
    add(NOP,   0, 0, 0, 0, 0,  0,  0, 20, 5'b00000, 0, 0);
    // Admin sets kind2 to 750 won; zero write refused; coin in ADMIN returned.
    add(NOP,   1, 0, 0, 0, 0,  0,  0, 20, 5'b00000, 0, 0);
    add(WR,    1, 2, 0, 0, 15, 1,  0, 20, 5'b00000, 0, 0);
    add(NOP,   1, 2, 0, 0, 0,  1,  0, 15, 5'b00000, 0, 0);
    add(WR,    1, 2, 0, 0, 0,  1,  0, 15, 5'b00010, 0, 0);
    add(COIN,  1, 2, 0, 0, 0,  1,  0, 15, 5'b01000, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  1,  0, 15, 5'b00000, 0, 0);
    // 1500 won in, one kind2 out, 750 back as 500+100+100+50.
    add(START, 0, 2, 0, 0, 0,  0,  0, 15, 5'b00000, 0, 0);
    add(COIN,  0, 2, 0, 3, 0,  2,  0, 15, 5'b00000, 0, 0);
    add(COIN,  0, 2, 0, 2, 0,  2, 20, 15, 5'b00000, 0, 0);
    add(ENTER, 0, 2, 1, 0, 0,  2, 30, 15, 5'b00000, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  3, 30, 15, 5'b00000, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  4, 15, 15, 5'b10000, 0, 2);
    add(COIN,  0, 2, 0, 1, 0,  5, 15, 15, 5'b01100, 2, 0);
    add(NOP,   0, 2, 0, 0, 0,  5,  5, 15, 5'b00100, 1, 0);
    add(NOP,   0, 2, 0, 0, 0,  5,  3, 15, 5'b00100, 1, 0);
    add(NOP,   0, 2, 0, 0, 0,  5,  1, 15, 5'b00100, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  5,  0, 15, 5'b00000, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  6,  0, 15, 5'b00001, 0, 0);
    add(NOP,   0, 2, 0, 0, 0,  0,  0, 15, 5'b00000, 0, 0);
    // num 0 and cost>credit rejected (coin with ENTER counted first), then CANCEL beats ENTER.
    add(START,        0, 0, 0, 0, 0, 0,  0, 20, 5'b00000, 0, 0);
    add(COIN,         0, 0, 0, 3, 0, 2,  0, 20, 5'b00000, 0, 0);
    add(ENTER_COIN,   0, 0, 0, 0, 0, 2, 20, 20, 5'b00000, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 3, 21, 20, 5'b00010, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 2, 21, 20, 5'b00000, 0, 0);
    add(ENTER_COIN,   0, 0, 2, 0, 0, 2, 21, 20, 5'b00000, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 3, 22, 20, 5'b00010, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 2, 22, 20, 5'b00000, 0, 0);
    add(CANCEL_ENTER, 0, 0, 1, 0, 0, 2, 22, 20, 5'b00000, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 5, 22, 20, 5'b00100, 3, 0);
    add(NOP,          0, 0, 0, 0, 0, 5,  2, 20, 5'b00100, 1, 0);
    add(NOP,          0, 0, 0, 0, 0, 5,  0, 20, 5'b00000, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 6,  0, 20, 5'b00001, 0, 0);
    add(NOP,          0, 0, 0, 0, 0, 0,  0, 20, 5'b00000, 0, 0);

    rst_n = 1'b0;
    drive(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 20, 5'b00000, 0, 0));
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst.state", bus.state, 0);
    chk("rst.credit", bus.credit, 0);
    chk("rst.made", bus.made, 0);
    chk("rst.made_kind", bus.made_kind, 0);
    chk("rst.change_valid", bus.change_valid, 0);
    chk("rst.change_coin", bus.change_coin, 0);
    chk("rst.err", bus.err, 0);
    chk("rst.end", bus.session_end, 0);
    chk("rst.coin_reject", bus.coin_reject, 0);
    for (int k = 0; k < 4; k++) begin
      bus.kind = KIND_W'(k);
      #1;
      chk($sformatf("rst.price%0d", k), bus.price, 20);
    end
    bus.kind = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++)
      run(vq[i]);

    // Credit ceiling: 390 refuses 1000, takes 500 to reach 400, refuses 50; cancel refunds 20x1000.
    run(mk(START, 0, 0, 0, 0, 0, 0, 0, 20, 5'b00000, 0, 0));
    for (int i = 0; i < 19; i++)
      run(mk(COIN, 0, 0, 0, 3, 0, 2, i * 20, 20, 5'b00000, 0, 0));
    run(mk(COIN,   0, 0, 0, 2, 0, 2, 380, 20, 5'b00000, 0, 0));
    run(mk(COIN,   0, 0, 0, 3, 0, 2, 390, 20, 5'b01000, 0, 0));
    run(mk(COIN,   0, 0, 0, 2, 0, 2, 390, 20, 5'b00000, 0, 0));
    run(mk(COIN,   0, 0, 0, 0, 0, 2, 400, 20, 5'b01000, 0, 0));
    run(mk(CANCEL, 0, 0, 0, 0, 0, 2, 400, 20, 5'b00000, 0, 0));
    for (int i = 0; i < 20; i++)
      run(mk(NOP, 0, 0, 0, 0, 0, 5, 400 - i * 20, 20, 5'b00100, 3, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 5, 0, 20, 5'b00000, 0, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 6, 0, 20, 5'b00001, 0, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 20, 5'b00000, 0, 0));

    // Reset during DISPENSE drops credit and restores default prices, no change paid.
    run(mk(START, 0, 2, 0, 0, 0, 0,  0, 15, 5'b00000, 0, 0));
    run(mk(COIN,  0, 2, 0, 3, 0, 2,  0, 15, 5'b00000, 0, 0));
    run(mk(COIN,  0, 2, 0, 3, 0, 2, 20, 15, 5'b00000, 0, 0));
    run(mk(COIN,  0, 2, 0, 3, 0, 2, 40, 15, 5'b00000, 0, 0));
    run(mk(ENTER, 0, 2, 3, 0, 0, 2, 60, 15, 5'b00000, 0, 0));
    run(mk(NOP,   0, 2, 0, 0, 0, 3, 60, 15, 5'b00000, 0, 0));
    rst_n = 1'b0;
    run(mk(NOP,   0, 2, 0, 0, 0, 4, 15, 15, 5'b10000, 0, 2));
    rst_n = 1'b1;
    run(mk(NOP,   0, 2, 0, 0, 0, 0,  0, 20, 5'b00000, 0, 0));
    chk("rst_mid.made_kind", bus.made_kind, 0);
    run(mk(NOP,   0, 2, 0, 0, 0, 0,  0, 20, 5'b00000, 0, 0));

`ifdef AUTO_REFUND_TIMEOUT_EN
    // Idle COLLECT with 100 won refunds after exactly TO_CYC quiet cycles.
    run(mk(START, 0, 0, 0, 0, 0, 0, 0, 20, 5'b00000, 0, 0));
    run(mk(COIN,  0, 0, 0, 1, 0, 2, 0, 20, 5'b00000, 0, 0));
    for (int i = 0; i < TO_CYC; i++)
      run(mk(NOP, 0, 0, 0, 0, 0, 2, 2, 20, 5'b00000, 0, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 5, 2, 20, 5'b00100, 1, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 5, 0, 20, 5'b00000, 0, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 6, 0, 20, 5'b00001, 0, 0));
    run(mk(NOP, 0, 0, 0, 0, 0, 0, 0, 20, 5'b00000, 0, 0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
